// File: rtl/accel_dispatch_ctrl.sv
// accel_dispatch_ctrl
// Dispatches host control packets to the accelerator units. Packets are
// buffered in a small FIFO, then decoded and issued one at a time on a shared
// command bus. The next command is issued only after the addressed unit
// reports completion. COPY and ADD_VEC run as two phases: the source unit
// first (phase 0), then the target unit (phase 1).
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   pkt_valid / pkt_ready           host packet handshake (ready = FIFO not full)
//   pkt_unit_id, pkt_src_unit_id    target unit, source unit (two-phase ops)
//   pkt_ctrl                        [2:0] op, [4:3] comp type, [5] unused
//   pkt_config                      [3:0] addr, [6:4] size, [7] unused
//   cmd_valid / cmd_ready           command bus handshake
//   cmd_unit_id ... cmd_phase       command fields, stable while cmd_valid
//   done_valid, done_unit_id        completion pulse from a unit
//   busy                            FSM active or packets still buffered
//   err                             one-cycle pulse: illegal op or timeout
// All outputs come straight from flops.

module accel_dispatch_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    output logic       pkt_ready,
    input  logic [7:0] pkt_unit_id,
    input  logic [7:0] pkt_src_unit_id,
    input  logic [5:0] pkt_ctrl,
    input  logic [7:0] pkt_config,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_unit_id,
    output logic [7:0] cmd_src_unit_id,
    output logic [2:0] cmd_op,
    output logic [1:0] cmd_comp,
    output logic [3:0] cmd_addr,
    output logic [2:0] cmd_size,
    output logic       cmd_phase,
    input  logic       done_valid,
    input  logic [7:0] done_unit_id,
    output logic       busy,
    output logic       err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_LOAD    = 3'b001;
    localparam logic [2:0] OP_STORE   = 3'b010;
    localparam logic [2:0] OP_COMPUTE = 3'b011;
    localparam logic [2:0] OP_COPY    = 3'b100;
    localparam logic [2:0] OP_ADD_VEC = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0] unit_id;
        logic [7:0] src_unit_id;
        logic [2:0] op;
        logic [1:0] comp;
        logic [3:0] addr;
        logic [2:0] size;
    } pkt_t;

    // ------------------------------------------------------------------
    // Packet FIFO
    // ------------------------------------------------------------------
    pkt_t             fifo_mem [FIFO_DEPTH];
    pkt_t             in_pkt;
    pkt_t             head_pkt;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    // Reserved control/config bits are deliberately dropped.
    logic unused_rsvd_bits;
    assign unused_rsvd_bits = pkt_ctrl[5] ^ pkt_config[7];

    assign in_pkt = '{
        unit_id:     pkt_unit_id,
        src_unit_id: pkt_src_unit_id,
        op:          pkt_ctrl[2:0],
        comp:        pkt_ctrl[4:3],
        addr:        pkt_config[3:0],
        size:        pkt_config[6:4]
    };

    assign head_pkt = fifo_mem[rd_ptr_q];

    // ------------------------------------------------------------------
    // FSM and command register
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    pkt_t             cur_q, cur_d;
    logic [7:0]       cmd_unit_q, cmd_unit_d;
    logic             phase_q, phase_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             busy_q, busy_d;
    logic             pkt_ready_q, pkt_ready_d;
    logic             done_match;
    logic             two_phase;

    assign push       = pkt_valid && pkt_ready_q;
    assign done_match = done_valid && (done_unit_id == cmd_unit_q);
    assign two_phase  = (cur_q.op == OP_COPY) || (cur_q.op == OP_ADD_VEC);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d    = state_q;
        cur_d      = cur_q;
        cmd_unit_d = cmd_unit_q;
        phase_d    = phase_q;
        tmo_d      = tmo_q;
        err_d      = 1'b0;
        pop        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    unique case (head_pkt.op)
                        OP_NOP: ;  // discarded, one IDLE cycle spent
                        OP_LOAD, OP_STORE, OP_COMPUTE: begin
                            cur_d      = head_pkt;
                            cmd_unit_d = head_pkt.unit_id;
                            phase_d    = 1'b0;
                            state_d    = ST_ISSUE;
                        end
                        OP_COPY, OP_ADD_VEC: begin
                            cur_d      = head_pkt;
                            cmd_unit_d = head_pkt.src_unit_id;
                            phase_d    = 1'b0;
                            state_d    = ST_ISSUE;
                        end
                        default: err_d = 1'b1;  // illegal op, dropped
                    endcase
                end
            end

            ST_ISSUE: begin
                if (cmd_ready) begin
                    state_d = ST_WAIT;
                    tmo_d   = '0;
                end
            end

            ST_WAIT: begin
                if (done_match) begin
                    if (two_phase && !phase_q) begin
                        phase_d    = 1'b1;
                        cmd_unit_d = cur_q.unit_id;
                        state_d    = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 2)) begin
                    // Decided one cycle early: the err flop adds a cycle, so
                    // err lands exactly TIMEOUT_CYCLES after the handshake.
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO bookkeeping; a push and a pop in the same cycle both take effect.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Registered status outputs reflect the state being entered.
    always_comb begin
        cmd_valid_d = (state_d == ST_ISSUE);
        busy_d      = (state_d != ST_IDLE) || (count_d != '0);
        pkt_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            cmd_unit_q  <= '0;
            phase_q     <= 1'b0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            pkt_ready_q <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            cmd_unit_q  <= cmd_unit_d;
            phase_q     <= phase_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
            pkt_ready_q <= pkt_ready_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: the storage array is not reset; the pointers and count are, and
    // an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= in_pkt;
        end
    end

    assign pkt_ready       = pkt_ready_q;
    assign cmd_valid       = cmd_valid_q;
    assign cmd_unit_id     = cmd_unit_q;
    assign cmd_src_unit_id = cur_q.src_unit_id;
    assign cmd_op          = cur_q.op;
    assign cmd_comp        = cur_q.comp;
    assign cmd_addr        = cur_q.addr;
    assign cmd_size        = cur_q.size;
    assign cmd_phase       = phase_q;
    assign busy            = busy_q;
    assign err             = err_q;

endmodule

// File: tb/tb_accel_dispatch_ctrl.sv
// Self-checking bench for accel_dispatch_ctrl (FIFO_DEPTH 4, TIMEOUT_CYCLES 8).
// Inputs are driven 1 time unit after each rising edge and outputs are sampled
// at the same point, so every check sees the registered outputs of the cycle
// whose inputs are being set.

module tb_accel_dispatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pkt_valid = 1'b0;
    logic       pkt_ready;
    logic [7:0] pkt_unit_id = '0;
    logic [7:0] pkt_src_unit_id = '0;
    logic [5:0] pkt_ctrl = '0;
    logic [7:0] pkt_config = '0;
    logic       cmd_valid;
    logic       cmd_ready = 1'b0;
    logic [7:0] cmd_unit_id;
    logic [7:0] cmd_src_unit_id;
    logic [2:0] cmd_op;
    logic [1:0] cmd_comp;
    logic [3:0] cmd_addr;
    logic [2:0] cmd_size;
    logic       cmd_phase;
    logic       done_valid = 1'b0;
    logic [7:0] done_unit_id = '0;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    accel_dispatch_ctrl #(
        .FIFO_DEPTH    (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .pkt_unit_id    (pkt_unit_id),
        .pkt_src_unit_id(pkt_src_unit_id),
        .pkt_ctrl       (pkt_ctrl),
        .pkt_config     (pkt_config),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_unit_id    (cmd_unit_id),
        .cmd_src_unit_id(cmd_src_unit_id),
        .cmd_op         (cmd_op),
        .cmd_comp       (cmd_comp),
        .cmd_addr       (cmd_addr),
        .cmd_size       (cmd_size),
        .cmd_phase      (cmd_phase),
        .done_valid     (done_valid),
        .done_unit_id   (done_unit_id),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] unit;
        logic [7:0] src;
        logic [5:0] ctrl;
        logic [7:0] cfg;
        logic       cmd_ready;
        logic       done;
        logic [7:0] done_unit;
    } in_t;

    typedef struct {
        logic       ready;
        logic       cmd_valid;
        logic [7:0] unit;
        logic [2:0] op;
        logic [1:0] comp;
        logic [3:0] addr;
        logic [2:0] size;
        logic       phase;
        logic       busy;
        logic       err;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle; a packet accepted at this edge is withdrawn and a
    // done pulse lasts one cycle.
    task automatic tick();
        logic acc;
        acc = pkt_valid && pkt_ready;
        @(posedge clk);
        #1;
        if (acc) pkt_valid = 1'b0;
        done_valid = 1'b0;
    endtask

    task automatic offer(input logic [7:0] unit, input logic [7:0] src,
                         input logic [5:0] ctrl, input logic [7:0] cfg);
        pkt_valid       = 1'b1;
        pkt_unit_id     = unit;
        pkt_src_unit_id = src;
        pkt_ctrl        = ctrl;
        pkt_config      = cfg;
    endtask

    task automatic send_done(input logic [7:0] unit);
        done_valid   = 1'b1;
        done_unit_id = unit;
    endtask

    initial begin
        logic [7:0] fifo_units [6];
        int         waited;

        // LOAD unit 5 (ctrl bit5 / cfg bit7 set, must be ignored), done at H
        // ignored, done at H+2 completes; then NOP, illegal 110, STORE unit 1.
        vecs[0]  = '{'{1'b1, 8'd5, 8'd0, 6'h21, 8'hA3, 1'b1, 1'b0, 8'd0},
                     '{1'b1, 1'b0, 8'd0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0}};
        vecs[1]  = '{'{1'b0, 8'd0, 8'd0, 6'h00, 8'h00, 1'b1, 1'b0, 8'd0},
                     '{1'b1, 1'b0, 8'd0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0}};
        vecs[2]  = '{'{1'b0, 8'd0, 8'd0, 6'h00, 8'h00, 1'b1, 1'b1, 8'd5},
                     '{1'b1, 1'b1, 8'd5, 3'd1, 2'd0, 4'd3, 3'd2, 1'b0, 1'b1, 1'b0}};
        vecs[3]  = '{'{1'b0, 8'd0, 8'd0, 6'h00, 8'h00, 1'b1, 1'b0, 8'd0},
                     '{1'b1, 1'b0, 8'd0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0}};
        vecs[4]  = '{'{1'b0, 8'd0, 8'd0, 6'h00, 8'h00, 1'b1, 1'b1, 8'd5},
                     '{1'b1, 1'b0, 8'd0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0}};
        vecs[5]  = '{'{1'b0, 8'd0, 8'd0, 6'h00, 8'h00, 1'b1, 1'b0, 8'd0},
                     '{1'b1, 1'b0, 8'd0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0}};
        vecs[6]  = '{'{1'b1, 8'd0, 8'd0, 6'h00, 8'h00, 1'b1, 1'b0, 8'd0},
                     '{1'b1, 1'b0, 8'd0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0}};
        vecs[7]  = '{'{1'b1, 8'd2, 8'd0, 6'h06, 8'h00, 1'b1, 1'b0, 8'd0},
                     '{1'b1, 1'b0, 8'd0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0}};
        vecs[8]  = '{'{1'b1, 8'd1, 8'd0, 6'h12, 8'h57, 1'b0, 1'b0, 8'd0},
                     '{1'b1, 1'b0, 8'd0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0}};
        vecs[9]  = '{'{1'b0, 8'd0, 8'd0, 6'h00, 8'h00, 1'b0, 1'b0, 8'd0},
                     '{1'b1, 1'b0, 8'd0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1}};
        vecs[10] = '{'{1'b0, 8'd0, 8'd0, 6'h00, 8'h00, 1'b0, 1'b0, 8'd0},
                     '{1'b1, 1'b1, 8'd1, 3'd2, 2'd2, 4'd7, 3'd5, 1'b0, 1'b1, 1'b0}};
        vecs[11] = '{'{1'b0, 8'd0, 8'd0, 6'h00, 8'h00, 1'b1, 1'b0, 8'd0},
                     '{1'b1, 1'b1, 8'd1, 3'd2, 2'd2, 4'd7, 3'd5, 1'b0, 1'b1, 1'b0}};
        vecs[12] = '{'{1'b0, 8'd0, 8'd0, 6'h00, 8'h00, 1'b1, 1'b1, 8'd3},
                     '{1'b1, 1'b0, 8'd0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0}};
        vecs[13] = '{'{1'b0, 8'd0, 8'd0, 6'h00, 8'h00, 1'b1, 1'b1, 8'd1},
                     '{1'b1, 1'b0, 8'd0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0}};
        vecs[14] = '{'{1'b0, 8'd0, 8'd0, 6'h00, 8'h00, 1'b1, 1'b0, 8'd0},
                     '{1'b1, 1'b0, 8'd0, 3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0}};

        // Reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset.cmd_fields",
              {cmd_unit_id, cmd_src_unit_id, cmd_op, cmd_comp, cmd_addr, cmd_size, cmd_phase},
              32'd0);

        // Table-driven part
        for (int k = 0; k < NV; k++) begin
            check($sformatf("v%0d.pkt_ready", k), pkt_ready, vecs[k].e.ready);
            check($sformatf("v%0d.cmd_valid", k), cmd_valid, vecs[k].e.cmd_valid);
            check($sformatf("v%0d.busy", k), busy, vecs[k].e.busy);
            check($sformatf("v%0d.err", k), err, vecs[k].e.err);
            if (vecs[k].e.cmd_valid) begin
                check($sformatf("v%0d.unit", k), cmd_unit_id, vecs[k].e.unit);
                check($sformatf("v%0d.op", k), cmd_op, vecs[k].e.op);
                check($sformatf("v%0d.comp", k), cmd_comp, vecs[k].e.comp);
                check($sformatf("v%0d.addr", k), cmd_addr, vecs[k].e.addr);
                check($sformatf("v%0d.size", k), cmd_size, vecs[k].e.size);
                check($sformatf("v%0d.phase", k), cmd_phase, vecs[k].e.phase);
            end
            pkt_valid       = vecs[k].i.valid;
            pkt_unit_id     = vecs[k].i.unit;
            pkt_src_unit_id = vecs[k].i.src;
            pkt_ctrl        = vecs[k].i.ctrl;
            pkt_config      = vecs[k].i.cfg;
            cmd_ready       = vecs[k].i.cmd_ready;
            done_valid      = vecs[k].i.done;
            done_unit_id    = vecs[k].i.done_unit;
            tick();
        end

        // COPY src 7 -> dst 9, comp 0, addr 5, size 1
        cmd_ready = 1'b1;
        offer(8'd9, 8'd7, 6'h04, 8'h15);
        tick();
        tick();
        check("copy.p0_valid", cmd_valid, 1'b1);
        check("copy.p0_unit", cmd_unit_id, 8'd7);
        check("copy.p0_src", cmd_src_unit_id, 8'd7);
        check("copy.p0_op", cmd_op, 3'd4);
        check("copy.p0_phase", cmd_phase, 1'b0);
        check("copy.p0_addr_size", {cmd_addr, cmd_size}, {4'd5, 3'd1});
        tick();
        send_done(8'd12);
        tick();
        check("copy.done12_ignored", cmd_valid, 1'b0);
        send_done(8'd9);
        tick();
        check("copy.done9_early_ignored", {cmd_valid, busy}, 2'b01);
        send_done(8'd7);
        tick();
        check("copy.p1_valid", cmd_valid, 1'b1);
        check("copy.p1_unit", cmd_unit_id, 8'd9);
        check("copy.p1_src", cmd_src_unit_id, 8'd7);
        check("copy.p1_phase", cmd_phase, 1'b1);
        check("copy.p1_op", cmd_op, 3'd4);
        tick();
        send_done(8'd9);
        tick();
        check("copy.idle", {cmd_valid, busy, err}, 3'b000);

        // FIFO full: unit 19 stuck in ISSUE, then push 20..24 back to back
        cmd_ready = 1'b0;
        offer(8'd19, 8'd0, 6'h01, 8'h00);
        tick();
        tick();
        check("fifo.u19_issue", {cmd_valid, cmd_unit_id}, {1'b1, 8'd19});
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fifo.ready_push%0d", k), pkt_ready, 1'b1);
            offer(8'(20 + k), 8'd0, 6'h01, 8'h00);
            tick();
        end
        offer(8'd24, 8'd0, 6'h01, 8'h00);
        check("fifo.full_ready", pkt_ready, 1'b0);
        tick();
        check("fifo.full_hold", {pkt_ready, cmd_valid, cmd_unit_id}, {1'b0, 1'b1, 8'd19});
        fifo_units = '{8'd19, 8'd20, 8'd21, 8'd22, 8'd23, 8'd24};
        cmd_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            waited = 0;
            while (!cmd_valid && waited < 16) begin
                tick();
                waited++;
            end
            check($sformatf("fifo.issue%0d_seen", k), cmd_valid, 1'b1);
            check($sformatf("fifo.issue%0d_unit", k), cmd_unit_id, fifo_units[k]);
            tick();
            send_done(fifo_units[k]);
            tick();
        end
        check("fifo.drained", {busy, pkt_ready, cmd_valid}, 3'b010);

        // Timeout on ADD_VEC phase 0 (src 31, dst 30, comp 1); LOAD 40 follows
        offer(8'd30, 8'd31, 6'h0D, 8'h00);
        tick();
        offer(8'd40, 8'd0, 6'h01, 8'h00);
        tick();
        check("tmo.p0_unit", {cmd_valid, cmd_unit_id, cmd_phase}, {1'b1, 8'd31, 1'b0});
        check("tmo.p0_op_comp", {cmd_op, cmd_comp}, {3'd5, 2'd1});
        tick();
        for (int k = 1; k < 8; k++) begin
            check($sformatf("tmo.wait%0d", k), {cmd_valid, err, busy}, 3'b001);
            tick();
        end
        check("tmo.err", err, 1'b1);
        tick();
        check("tmo.err_pulse", err, 1'b0);
        check("tmo.next_pkt", {cmd_valid, cmd_unit_id, cmd_phase}, {1'b1, 8'd40, 1'b0});
        tick();
        send_done(8'd40);
        tick();
        check("tmo.idle", {cmd_valid, busy, err}, 3'b000);

        // Reset during WAIT with two packets buffered
        offer(8'd50, 8'd0, 6'h01, 8'h00);
        tick();
        offer(8'd51, 8'd0, 6'h01, 8'h00);
        tick();
        offer(8'd52, 8'd0, 6'h01, 8'h00);
        check("rst.pre_issue", {cmd_valid, cmd_unit_id}, {1'b1, 8'd50});
        tick();
        check("rst.pre_wait", {cmd_valid, busy}, 2'b01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst.after", {cmd_valid, pkt_ready, busy, err}, 4'b0100);
        send_done(8'd50);
        tick();
        check("rst.late_done", {cmd_valid, busy, err}, 3'b000);
        tick();
        tick();
        check("rst.buffer_lost", {cmd_valid, busy}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/accel_dispatch_ctrl.md
# accel_dispatch_ctrl

Command dispatcher sitting between the host control-packet stream and the 256 accelerator units. Buffers incoming control packets, decodes them into op/compute/addr/size fields, and issues them one at a time on a shared command bus, waiting for the addressed unit's completion before issuing the next. Two-unit operations (OP_COPY, OP_ADD_VEC) are sequenced as a source-unit phase followed by a target-unit phase.

## Interface
- FIFO_DEPTH, 4: packet buffer entries (power of two, ≥2)
- TIMEOUT_CYCLES, 1024: max cycles waiting for done before abort (≥2)
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- pkt_valid  in  1  packet offered
- pkt_ready  out  1  buffer can accept; high iff FIFO not full
- pkt_unit_id  in  8  target unit
- pkt_src_unit_id  in  8  source unit (COPY/ADD_VEC only)
- pkt_ctrl  in  6  [2:0] op code, [4:3] comp type, [5] ignored
- pkt_config  in  8  [3:0] addr, [6:4] size, [7] ignored
- cmd_valid  out  1  command presented on bus
- cmd_ready  in  1  addressed unit accepts
- cmd_unit_id  out  8  unit addressed this phase
- cmd_src_unit_id  out  8  packet source unit, passed through
- cmd_op  out  3  op code
- cmd_comp  out  2  comp type
- cmd_addr  out  4  address
- cmd_size  out  3  size
- cmd_phase  out  1  0 = source phase / single-phase op, 1 = target phase
- done_valid  in  1  unit completion pulse
- done_unit_id  in  8  completing unit
- busy  out  1  high when not IDLE or FIFO non-empty
- err  out  1  one-cycle pulse: illegal op or timeout

## Operation
- Op codes: 000 NOP, 001 LOAD, 010 STORE, 011 COMPUTE, 100 COPY, 101 ADD_VEC; 110/111 illegal.
- FIFO push on pkt_valid && pkt_ready. No bypass: a push and pop in the same cycle both take effect; when full, pkt_ready is low even if a pop occurs that cycle.
- States: IDLE, ISSUE, WAIT.
- IDLE: if FIFO non-empty, pop head into command register. NOP → stay IDLE (packet discarded). Illegal → err pulse, stay IDLE. LOAD/STORE/COMPUTE → ISSUE, phase 0, cmd_unit_id = unit_id. COPY/ADD_VEC → ISSUE, phase 0, cmd_unit_id = src_unit_id.
- ISSUE: cmd_valid high, all cmd_* stable until cmd_valid && cmd_ready; then → WAIT, timeout counter cleared.
- WAIT: done_valid && done_unit_id == cmd_unit_id completes the phase. Done from any other unit ignored. Two-phase op at phase 0 → ISSUE, phase 1, cmd_unit_id = unit_id. Otherwise → IDLE.
- Timeout: counter increments each WAIT cycle; on reaching TIMEOUT_CYCLES without matching done → err pulse, → IDLE, command dropped (phase 1 of a two-phase op is not issued).
- done_valid outside WAIT is ignored.
- Reset: FIFO emptied, state IDLE, counter 0; mid-operation commands lost, no err.

## Timing
- Reset values: pkt_ready 1, cmd_valid 0, all cmd_* 0, busy 0, err 0.
- Packet accepted cycle N into empty FIFO, FSM IDLE: pop at N+1, cmd_valid high from N+2.
- Handshake at cycle H: WAIT from H+1; done sampled from H+1 onward (done at H ignored).
- Matching done at M: phase-1 cmd_valid or next IDLE at M+1; next packet pop at M+1 if IDLE, its cmd_valid at M+2.
- NOP/illegal consume one IDLE cycle each.
- Timeout: WAIT entered at H+1 with no done → err at cycle H+TIMEOUT_CYCLES, IDLE next cycle.
- All outputs registered.

## Test plan
- LOAD unit 5 addr 3 size 2, cmd_ready immediate, done from 5 two cycles later → one cmd (unit 5, op 001, phase 0, addr 3, size 2) at N+2; busy falls after done; no err.
- COPY src 7 → dst 9: phase 0 to unit 7, done 7; phase 1 to unit 9 at done+1; done 9 → IDLE; done from unit 12 in between ignored.
- Push 5 packets back-to-back with cmd_ready low: pkt_ready drops after 4 accepted; raise cmd_ready/dones → all 4 issued in order, fifth accepted once space frees.
- Packets NOP, op 110, STORE unit 1: no cmd for first two, err one cycle for 110, STORE issued afterward.
- TIMEOUT_CYCLES=8, ADD_VEC with no done on phase 0 → err after 8 WAIT cycles, phase 1 never issued, next packet proceeds.
- rst asserted during WAIT with 2 packets buffered → next cycle cmd_valid 0, pkt_ready 1, busy 0; late done ignored.
